// File: rtl/core_pkg.sv
// Shared core definitions: ALU op codes and forwarding selects.
// Used by the EX stage, Mem_Stage and the hazard unit.
// No logic; constants and widths only.
package core_pkg;

  localparam int CORE_DATA_W = 32;
  localparam int CORE_REG_W  = 5;

  // ALU operation codes carried on ALUControlE
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // Forward selects driven by the hazard unit (2'b11 is reserved, acts as FWD_RF)
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/execute_stage_if.sv
// ID/EX inputs, EX/MEM outputs and fetch-redirect signals of the EX stage.
// Latency: n/a (bundle of wires).
// Backpressure: none; the pipeline advances every cycle.
interface execute_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
);

  // ID/EX side
  logic              RegWriteE;
  logic              MemWriteE;
  logic              ResultSrcE;
  logic              BranchE;
  logic              JumpE;
  logic              ALUSrcE;
  logic [2:0]        ALUControlE;
  logic [DATA_W-1:0] RD1_E;
  logic [DATA_W-1:0] RD2_E;
  logic [DATA_W-1:0] Imm_Ext_E;
  logic [DATA_W-1:0] PCE;
  logic [DATA_W-1:0] PCPlus4E;
  logic [REG_W-1:0]  RD_E;
  logic [1:0]        ForwardA_E;
  logic [1:0]        ForwardB_E;
  logic [DATA_W-1:0] ResultW;

  // Fetch redirect
  logic              PCSrcE;
  logic [DATA_W-1:0] PCTargetE;

  // EX/MEM side
  logic              RegWriteM;
  logic              MemWriteM;
  logic              ResultSrcM;
  logic [REG_W-1:0]  RD_M;
  logic [DATA_W-1:0] PCPlus4M;
  logic [DATA_W-1:0] WriteDataM;
  logic [DATA_W-1:0] ALU_ResultM;

  // Upstream / environment view: drives the instruction, observes results
  modport master (
    output RegWriteE, MemWriteE, ResultSrcE, BranchE, JumpE, ALUSrcE,
           ALUControlE, RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, RD_E,
           ForwardA_E, ForwardB_E, ResultW,
    input  PCSrcE, PCTargetE, RegWriteM, MemWriteM, ResultSrcM, RD_M,
           PCPlus4M, WriteDataM, ALU_ResultM
  );

  // EX stage view
  modport slave (
    input  RegWriteE, MemWriteE, ResultSrcE, BranchE, JumpE, ALUSrcE,
           ALUControlE, RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, RD_E,
           ForwardA_E, ForwardB_E, ResultW,
    output PCSrcE, PCTargetE, RegWriteM, MemWriteM, ResultSrcM, RD_M,
           PCPlus4M, WriteDataM, ALU_ResultM
  );

endinterface

// File: rtl/alu.sv
// RV32I integer ALU: add, sub, and, or, signed slt; unknown ops give 0.
// Latency: combinational.
// Backpressure: none.
module alu
  import core_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] SrcA,
  input  logic [DATA_W-1:0] SrcB,
  input  logic [2:0]        ALUControl,
  output logic [DATA_W-1:0] Result,
  output logic              Zero
);

  logic slt_bit;

  assign slt_bit = ($signed(SrcA) < $signed(SrcB));

  // Operation select; add/sub wrap naturally at DATA_W bits
  always_comb begin
    Result = '0;
    case (ALUControl)
      ALU_ADD: Result = SrcA + SrcB;
      ALU_SUB: Result = SrcA - SrcB;
      ALU_AND: Result = SrcA & SrcB;
      ALU_OR:  Result = SrcA | SrcB;
      ALU_SLT: Result = {{(DATA_W-1){1'b0}}, slt_bit};
      default: Result = '0;
    endcase
  end

  assign Zero = (Result == '0);

endmodule

// File: rtl/execute_stage.sv
// EX stage: operand forwarding, ALU, branch/jump resolution, EX/MEM register.
// Latency: 1 cycle to *M outputs; PCSrcE/PCTargetE are combinational.
// Backpressure: none; the EX/MEM register loads every cycle and is never flushed.
module execute_stage
  import core_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic          clk,
  input  logic          rst,
  execute_stage_if.slave ex
);

  logic [DATA_W-1:0] src_a;
  logic [DATA_W-1:0] fwd_b;
  logic [DATA_W-1:0] src_b;
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;

  // Registered EX/MEM state; alu_result_m also feeds the MEM forward path
  logic              reg_write_m;
  logic              mem_write_m;
  logic              result_src_m;
  logic [REG_W-1:0]  rd_m;
  logic [DATA_W-1:0] pc_plus4_m;
  logic [DATA_W-1:0] write_data_m;
  logic [DATA_W-1:0] alu_result_m;

  // Operand A forward mux; reserved select 2'b11 falls back to the register file
  always_comb begin
    src_a = ex.RD1_E;
    case (ex.ForwardA_E)
      FWD_WB:  src_a = ex.ResultW;
      FWD_MEM: src_a = alu_result_m;
      default: src_a = ex.RD1_E;
    endcase
  end

  // Operand B forward mux; this value is also the store data
  always_comb begin
    fwd_b = ex.RD2_E;
    case (ex.ForwardB_E)
      FWD_WB:  fwd_b = ex.ResultW;
      FWD_MEM: fwd_b = alu_result_m;
      default: fwd_b = ex.RD2_E;
    endcase
  end

  assign src_b = ex.ALUSrcE ? ex.Imm_Ext_E : fwd_b;

  alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .SrcA       (src_a),
    .SrcB       (src_b),
    .ALUControl (ex.ALUControlE),
    .Result     (alu_result),
    .Zero       (alu_zero)
  );

  // Redirect is suppressed during reset so fetch never follows a stale target
  assign ex.PCSrcE    = rst & (ex.JumpE | (ex.BranchE & alu_zero));
  assign ex.PCTargetE = ex.PCE + ex.Imm_Ext_E;

  // EX/MEM pipeline register; reset overrides whatever instruction is in EX
  always_ff @(posedge clk) begin
    if (!rst) begin
      reg_write_m  <= 1'b0;
      mem_write_m  <= 1'b0;
      result_src_m <= 1'b0;
      rd_m         <= '0;
      pc_plus4_m   <= '0;
      write_data_m <= '0;
      alu_result_m <= '0;
    end else begin
      reg_write_m  <= ex.RegWriteE;
      mem_write_m  <= ex.MemWriteE;
      result_src_m <= ex.ResultSrcE;
      rd_m         <= ex.RD_E;
      pc_plus4_m   <= ex.PCPlus4E;
      write_data_m <= fwd_b;
      alu_result_m <= alu_result;
    end
  end

  assign ex.RegWriteM   = reg_write_m;
  assign ex.MemWriteM   = mem_write_m;
  assign ex.ResultSrcM  = result_src_m;
  assign ex.RD_M        = rd_m;
  assign ex.PCPlus4M    = pc_plus4_m;
  assign ex.WriteDataM  = write_data_m;
  assign ex.ALU_ResultM = alu_result_m;

endmodule
